// File: rtl/keccak_absorb_padder.sv
`default_nettype none
// ============================================================================
//  Module   : keccak_absorb_padder
//  Purpose  : Packs a byte-granular message, delivered as W-bit words, into
//             R-bit rate blocks for the Keccak permutation core. It applies
//             pad10*1 padding to the final block.
//  Ports    : clk, reset      - clock, synchronous active-high reset
//             din/din_valid/din_last/din_bytes/din_ready
//                             - message word input with valid/ready
//             blk_out/blk_ready/blk_ack
//                             - rate block toward the core (in_ready/ack)
//             done            - final padded block consumed; held until reset
//  Revision : 1.0 - initial release
// ============================================================================
module keccak_absorb_padder #(
  parameter  int F = 1600,
  parameter  int C = 1024,
  parameter  int W = 64,
  localparam int R = F - C
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         din_last,
  input  logic [2:0]   din_bytes,
  output logic         din_ready,
  output logic [R-1:0] blk_out,
  output logic         blk_ready,
  input  logic         blk_ack,
  output logic         done
);

  localparam int NW = R / W;
  localparam int CW = $clog2(NW + 1);
  localparam logic [CW-1:0] c_cnt_last = CW'(NW - 1);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_PAD  = 2'd1,
    S_FULL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  logic [R-1:0]  r_buf;
  logic [CW-1:0] r_cnt;
  logic          r_fin;
  logic [W-1:0]  w_last_word;
  logic [W-1:0]  w_word;
  logic          w_xfer;

  // Final word: keep bytes below din_bytes, put the 0x01 pad byte at
  // position din_bytes, zero the rest. Byte 0 sits in the MSBs.
  always_comb begin
    w_last_word = '0;
    for (int i = 0; i < W / 8; i++) begin
      if (i < int'(din_bytes)) begin
        w_last_word[W-1-8*i -: 8] = din[W-1-8*i -: 8];
      end else if (i == int'(din_bytes)) begin
        w_last_word[W-1-8*i -: 8] = 8'h01;
      end
    end
  end

  assign w_word = din_last ? w_last_word : din;
  // din_ready is only ever high in FILL, so it alone qualifies a transfer.
  assign w_xfer = din_valid & din_ready;

  // The trailing 0x80 of pad10*1 is merged on the output rather than into
  // the buffer, so it lands on the last byte of the block regardless of
  // how many zero words PAD shifted in.
  assign blk_out = {r_buf[R-1:8],
                    r_buf[7:0] | ((r_state == S_FULL && r_fin) ? 8'h80 : 8'h00)};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FILL;
      r_buf     <= '0;
      r_cnt     <= '0;
      r_fin     <= 1'b0;
      din_ready <= 1'b1;
      blk_ready <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_xfer) begin
            r_buf <= {r_buf[R-W-1:0], w_word};
            r_cnt <= r_cnt + 1'b1;
            if (din_last) begin
              r_fin <= 1'b1;
            end
            // A final word in the last slot completes the block directly.
            if (r_cnt == c_cnt_last) begin
              r_state   <= S_FULL;
              din_ready <= 1'b0;
              blk_ready <= 1'b1;
            end else if (din_last) begin
              r_state   <= S_PAD;
              din_ready <= 1'b0;
            end
          end
        end

        S_PAD: begin
          r_buf <= {r_buf[R-W-1:0], {W{1'b0}}};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_cnt_last) begin
            r_state   <= S_FULL;
            blk_ready <= 1'b1;
          end
        end

        S_FULL: begin
          if (blk_ack) begin
            r_buf     <= '0;
            r_cnt     <= '0;
            blk_ready <= 1'b0;
            if (r_fin) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end else begin
              r_state   <= S_FILL;
              din_ready <= 1'b1;
            end
          end
        end

        default: begin
          // S_DONE: terminal until reset.
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keccak_absorb_padder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keccak_absorb_padder
//  Purpose  : Self-checking bench for keccak_absorb_padder. Messages are
//             padded by a byte-level pad10*1 model and compared block by
//             block with the DUT output, along with handshake timing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keccak_absorb_padder;

  localparam int F  = 1600;
  localparam int C  = 1024;
  localparam int W  = 64;
  localparam int R  = F - C;
  localparam int NW = R / W;
  localparam int RB = R / 8;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [2:0]  nb;
  } word_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_last;
  logic [2:0]   din_bytes;
  logic         din_ready;
  logic [R-1:0] blk_out;
  logic         blk_ready;
  logic         blk_ack;
  logic         done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  keccak_absorb_padder #(.F(F), .C(C), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .din_last  (din_last),
    .din_bytes (din_bytes),
    .din_ready (din_ready),
    .blk_out   (blk_out),
    .blk_ready (blk_ready),
    .blk_ack   (blk_ack),
    .done      (done)
  );

  task automatic check(input string tag, input logic [R-1:0] got, input logic [R-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    din_valid = 1'b0;
    din_last  = 1'b0;
    din_bytes = 3'd0;
    din       = '0;
    blk_ack   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives one message and checks every block, the pad latency and done.
  task automatic run_message(input byte unsigned msg[$], input int ack_min,
                             input int ack_max, input int valid_pct);
    word_t          words[$];
    word_t          wd;
    logic [R-1:0]   exp_blk[$];
    logic [R-1:0]   blk;
    byte unsigned   pad[$];
    int             len, nwords, exp_lat, fin_wait, ack_cnt, ack_tgt, cyc;
    bit             prev_xfer, prev_ack;

    len    = msg.size();
    nwords = len / 8 + 1;
    for (int w = 0; w < nwords; w++) begin
      wd.data = {$urandom, $urandom};
      for (int i = 0; i < 8; i++)
        if (8 * w + i < len) wd.data[63-8*i -: 8] = msg[8*w+i];
      wd.last = (w == nwords - 1);
      wd.nb   = wd.last ? 3'(len % 8) : 3'($urandom);
      words.push_back(wd);
    end

    // pad10*1 at byte level: 0x01, zeros to a rate multiple, 0x80 on the end.
    pad = msg;
    pad.push_back(8'h01);
    while (pad.size() % RB != 0) pad.push_back(8'h00);
    pad[pad.size()-1] = pad[pad.size()-1] | 8'h80;
    for (int j = 0; j < pad.size() / RB; j++) begin
      blk = '0;
      for (int b = 0; b < RB; b++) blk[R-1-8*b -: 8] = pad[j*RB+b];
      exp_blk.push_back(blk);
    end
    exp_lat = NW - 1 - ((len / 8) % NW);

    do_reset();
    fin_wait  = -1;
    ack_cnt   = 0;
    ack_tgt   = $urandom_range(ack_max, ack_min);
    cyc       = 0;
    prev_xfer = 1'b0;
    prev_ack  = 1'b0;

    forever begin
      @(negedge clk);
      cyc++;
      if (prev_xfer) begin
        wd = words.pop_front();
        if (wd.last) fin_wait = 0;
      end
      if (prev_ack) begin
        void'(exp_blk.pop_front());
        ack_cnt = 0;
        ack_tgt = $urandom_range(ack_max, ack_min);
        if (exp_blk.size() == 0) begin
          check("done_after_final_ack", R'(done), R'(1));
          check("blk_ready_in_done", R'(blk_ready), R'(0));
          break;
        end
        check("done_before_final", R'(done), R'(0));
        check("din_ready_after_ack", R'(din_ready), R'(1));
      end
      if (fin_wait >= 0) begin
        if (blk_ready) begin
          check("pad_latency", R'(fin_wait), R'(exp_lat));
          fin_wait = -1;
        end else begin
          fin_wait++;
        end
      end
      if (blk_ready) begin
        check("blk_out", blk_out, exp_blk[0]);
        check("din_ready_in_full", R'(din_ready), R'(0));
        if (ack_cnt >= ack_tgt) begin
          blk_ack = 1'b1;
        end else begin
          blk_ack = 1'b0;
          ack_cnt++;
        end
      end else begin
        blk_ack = 1'($urandom);  // must be ignored while no block is presented
      end
      if (!(din_valid && !prev_xfer)) begin
        if (words.size() > 0) begin
          din_valid = ($urandom_range(99, 0) < valid_pct);
          din       = words[0].data;
          din_last  = words[0].last;
          din_bytes = words[0].nb;
        end else begin
          din_valid = 1'b0;
        end
      end
      prev_xfer = din_valid && din_ready;
      prev_ack  = blk_ack && blk_ready;
      if (cyc > 5000) begin
        check("timeout", R'(0), R'(1));
        break;
      end
    end

    blk_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din_valid = 1'($urandom);
      @(negedge clk);
      check("done_held", R'({done, din_ready, blk_ready}), R'(3'b100));
    end
    din_valid = 1'b0;
  endtask

  // Loads part of a message, resets mid-flight, checks nothing survives.
  task automatic abort_test(input int nfull, input bit send_last);
    byte unsigned empty[$];
    do_reset();
    for (int i = 0; i < nfull; i++) begin
      @(negedge clk);
      din_valid = 1'b1;
      din       = {$urandom | 32'h1, $urandom};
      din_last  = 1'b0;
      din_bytes = 3'd0;
    end
    if (send_last) begin
      @(negedge clk);
      din_last  = 1'b1;
      din_bytes = 3'd0;
    end
    @(negedge clk);
    din_valid = 1'b0;
    din_last  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_blk_out", blk_out, '0);
    check("abort_flags", R'({din_ready, blk_ready, done}), R'(3'b100));
    empty = {};
    run_message(empty, 0, 3, 100);
  endtask

  initial begin
    byte unsigned m[$];

    do_reset();
    check("reset_blk_out", blk_out, '0);
    check("reset_flags", R'({din_ready, blk_ready, done}), R'(3'b100));

    // Empty message.
    m = {};
    run_message(m, 0, 2, 100);

    // Nine full words 0x11.. .. 0x99.., then an empty final word.
    m = {};
    for (int i = 0; i < NW; i++)
      for (int b = 0; b < 8; b++) m.push_back(8'((i + 1) * 8'h11));
    run_message(m, 1, 3, 100);

    // 71 bytes: final word AABBCCDDEEFF11 lands in the last slot.
    m = {};
    for (int i = 0; i < 64; i++) m.push_back(8'($urandom));
    m.push_back(8'hAA); m.push_back(8'hBB); m.push_back(8'hCC); m.push_back(8'hDD);
    m.push_back(8'hEE); m.push_back(8'hFF); m.push_back(8'h11);
    run_message(m, 0, 2, 100);

    // "abc".
    m = {8'h61, 8'h62, 8'h63};
    run_message(m, 0, 2, 100);

    // Backpressure: core holds off 20 cycles per block while input stays valid.
    m = {};
    for (int i = 0; i < 100; i++) m.push_back(8'($urandom));
    run_message(m, 20, 20, 100);

    // Reset mid-FILL, mid-PAD and mid-FULL.
    abort_test(5, 1'b0);
    abort_test(2, 1'b1);
    abort_test(8, 1'b1);

    // Random messages, random gaps and ack delays.
    for (int t = 0; t < 25; t++) begin
      m = {};
      for (int i = 0, n = $urandom_range(200, 0); i < n; i++) m.push_back(8'($urandom));
      run_message(m, 0, 4, $urandom_range(100, 30));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keccak_absorb_padder.md
Name: keccak_absorb_padder

Overview:
- Upstream feeder for the Keccak permutation core in the integrity hash path.
- Accepts a byte-granular message as 64-bit words and packs the words into r-bit rate blocks.
- Applies Keccak pad10*1 padding to the final block.
- Presents each block on an in_ready/ack handshake; the permutation core acks combinationally when it is idle and XORs the block into its state.

Parameters:
- F, 1600, permutation state width in bits.
- C, 1024, capacity in bits. R = F - C = 576 is the block width.
- W, 64, input word width. NW = R / W = 9 words per block; R must be a multiple of W.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- din  in  W  message word. Byte 0 is din[63:56]; byte 7 is din[7:0].
- din_valid  in  1  din, din_last and din_bytes are valid this cycle.
- din_last  in  1  this word is the final word of the message.
- din_bytes  in  3  number of valid bytes (0..7) in a final word. Ignored when din_last=0.
- din_ready  out  1  block can accept a word this cycle.
- blk_out  out  R  rate block. Word 0 is at [R-1:R-W]; word NW-1 is at [W-1:0].
- blk_ready  out  1  blk_out holds a complete block. Connects to the core's in_ready.
- blk_ack  in  1  core consumed blk_out this cycle. Connects to the core's ack.
- done  out  1  final padded block has been acked. Held until reset.

Behaviour:
- Message framing:
  - A non-final word always carries 8 bytes.
  - A message whose length is a multiple of 8 ends with an extra din_last word with din_bytes=0.
  - An empty message is a single din_last word with din_bytes=0.
- Word transfer:
  - A word transfers when din_valid & din_ready.
  - It shifts into the block buffer: buf <= {buf[R-W-1:0], word}.
  - Word counter cnt (0..NW) increments by 1.
- States:
  - FILL: din_ready = (cnt < NW).
    - Non-final transfer: shift din, stay in FILL.
    - Final transfer with n = din_bytes: the shifted word is din with bytes n..7 replaced by {0x01, zeros}; set flag fin=1; go to PAD.
    - If cnt reaches NW in FILL: go to FULL.
  - PAD: din_ready=0. Shift one all-zero word per cycle until cnt = NW, then go to FULL.
  - FULL:
    - blk_ready=1, din_ready=0, blk_out held stable.
    - If fin=1, blk_out[7:0] shows buf[7:0] | 0x80. Pad 0x01 in byte 7 of word NW-1 therefore yields 0x81.
    - On blk_ack: clear buf and cnt to 0. If fin=1 go to DONE, else go to FILL.
  - DONE: done=1, din_ready=0, blk_ready=0. Exit only by reset.
- Timing:
  - blk_ready is registered. It rises the cycle after cnt becomes NW, including the cycle after the last PAD shift.
  - If the final word lands at index k < NW-1, PAD takes NW-1-k cycles.
- blk_ack while blk_ready=0 is ignored. din_valid while din_ready=0 is ignored; upstream must hold the word until the transfer.
- Reset values: buf=0, blk_out=0, cnt=0, fin=0, state=FILL, din_ready=1, blk_ready=0, done=0.
- Reset asserted mid-FILL, mid-PAD or mid-FULL discards the partial block immediately. Nothing is retained.
- din_bytes values are 0..7 only, so the pad byte 0x01 always fits in the final word. No extra padding-only block is ever required beyond the din_last word.

Test Plan:
- Empty message (din_last=1, din_bytes=0 at cnt=0) -> 8 PAD cycles; then one block with blk_out[575:568]=0x01, blk_out[7:0]=0x80, all other bits 0. After blk_ack, done=1 the next cycle.
- 9 full words 0x1111..., 0x2222... .. 0x9999..., then din_last with din_bytes=0 -> two blocks:
  - block 1 = the nine words in order, no 0x80;
  - block 2 = {0x01, zeros, 0x80};
  - done=1 only after the second ack.
- 8 full words, then last word 0xAABBCCDDEEFF1122 with din_bytes=7 -> single block. Word 8 = 0xAABBCCDDEEFF1181. blk_ready is asserted with no PAD cycles.
- 3-byte message 0x616263 (din_bytes=3) -> word 0 = 0x6162630100000000, words 1..8 zero with [7:0]=0x80. blk_ready rises 8 cycles after the transfer.
- Backpressure: hold blk_ack=0 for 20 cycles in FULL with din_valid=1 -> blk_out unchanged, din_ready=0, no word consumed. On the first ack, cnt=0 and din_ready=1 the next cycle.
- Assert reset after 5 words -> next cycle cnt=0, blk_out=0, blk_ready=0, din_ready=1. A subsequent empty message yields exactly the empty-message block.
